uart_rx_monitor: RTL
====================

Name: uart_rx_monitor

Overview:
- Downstream, bench-side consumer of the SoC top's serial console output.
- Decodes the UART TX line driven by the 16550 in the SoC into bytes, buffers them in a small FIFO, and presents them on a valid/ready stream to the bench console and checker.
- Shares the bench's single free-running clock and reset. It is synthesizable, so it can also be reused on FPGA.

Parameters:
- DIV, 16, clock cycles per UART bit; legal range >= 4; counter width is clog2(DIV).
- FIFO_DEPTH, 8, byte entries in the output FIFO; power of two, >= 2.

Ports:
- clock  input  1  single system clock, same net as the SoC top's clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  serial line from the SoC UART TX; idle is high.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head byte.
- out_data  output  8  head byte of the FIFO.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset values: out_valid=0, out_data=0, frame_err=0, overflow=0, fifo_count=0. FSM goes to IDLE; both synchronizer flops go to 1.
- Synchronizer: rxd passes through 2 flops (rxd_s). All decisions use rxd_s.
- FSM states:
  - IDLE: on rxd_s==0, clear bit counter, load div_cnt=DIV/2-1, go to START.
  - START: count down. At 0, sample rxd_s. If 0, load div_cnt=DIV-1 and go to DATA. If 1 (glitch), go to IDLE with no output and no error.
  - DATA: at each div_cnt==0, shift rxd_s into the shift register LSB-first and reload DIV-1. After the 8th bit, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: at div_cnt==0, sample. If 1, push the byte and go to IDLE. If 0, pulse frame_err, discard the byte and go to BREAK.
  - BREAK: wait for rxd_s==1, then go to IDLE.
- Latency: the pushed byte is on out_data with out_valid=1 on the cycle after the stop-bit sample.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when full and no pop in the same cycle: byte dropped, overflow set. overflow clears only on reset.
  - Push and pop in the same cycle while full: both happen; count unchanged; no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- out_data: registered FIFO read. When the FIFO is empty it holds its last value, and consumers ignore it while out_valid=0.
- Reset mid-frame: the partial byte is discarded, the FIFO is flushed, and there is no frame_err.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after STOP.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP; even parity over the 8 data bits, sampled like a data bit.
  - A mismatch pulses the extra output port parity_err (1 bit) at the stop sample and discards the byte.
  - A frame error takes precedence: only frame_err pulses.
- When undefined:
  - No PARITY state and no parity_err port.
  - Frame = start + 8 data + stop.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - BYTE_W=8.
  - function computing the counter width from DIV.
- One sub-module, uart_rx_fifo: parameterised by depth, with push/pop/full/empty/count, registered read data, and the same clock/reset.
- The FSM, synchronizer and overflow flag stay in uart_rx_monitor.

Test Plan:
1. DIV=16, out_ready=1, send 0x55 (8N1) -> exactly one out_valid pulse with out_data=0x55, 1 cycle after the stop sample (~152+2 cycles after the falling edge); frame_err=0.
2. Send 0x00, 0xFF, 0xA5 back-to-back with out_ready=0 -> fifo_count=3, then out_ready=1 pops 0x00, 0xFF, 0xA5 in order over 3 cycles.
3. 5-cycle low glitch on rxd -> no output, no frame_err, FSM returns to IDLE, the next frame 0x3C is decoded correctly.
4. Frame 0x81 with stop bit forced low for 2 bit times -> frame_err pulses once, fifo_count unchanged, the following 0x42 is received.
5. FIFO_DEPTH=8, out_ready=0, send 9 bytes -> fifo_count=8, overflow=1 and stays set. Also check: when full with out_ready=1 during the 9th stop sample, count stays 8 and overflow stays 0.
6. Assert reset during the 4th data bit of 0x99 -> all outputs return to reset values next cycle, no byte is produced, and a subsequent 0x99 is received. With UART_RX_PARITY_EN, a wrong parity bit on 0x07 -> parity_err pulse and no push.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive monitor: receiver states,
// byte width and the bit-timing counter width helper.
package uart_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Width of a down-counter that must hold DIV-1.
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with occupancy count and a registered head (rdata is the oldest
// entry whenever count != 0, and holds its last value when empty).
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;
    logic          head_is_wdata;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands if the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    // The incoming byte becomes the head when nothing older survives this cycle.
    assign head_is_wdata = do_push && (empty || ((count == {{AW{1'b0}}, 1'b1}) && do_pop));

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (head_is_wdata) begin
                rdata <= wdata;
            end else if (count_next != '0) begin
                rdata <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// Bench-side UART receiver: 2-flop synchronizer, bit-timing FSM and output FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rxd,
    // Stream: a byte transfers on a cycle where out_valid && out_ready; out_data
    // is stable while out_valid is high and not yet accepted.
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic [2:0]                    dbg_state
);

    localparam int              CW        = cnt_width(DIV);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(DIV - 1);

    logic              rxd_m;
    logic              rxd_s;
    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     div_q;
    logic [CW-1:0]     div_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;
    logic              push;
    logic              pop;
    logic              frame_err_d;
    logic              fifo_full;
    logic              fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic              par_q;
    logic              par_d;
    logic              parity_err_d;
`endif

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign dbg_state = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            frame_err  <= frame_err_d;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            parity_err <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    bit_d   = '0;
                    div_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (div_q == '0) begin
                    if (!rxd_s) begin
                        div_d   = FULL_LOAD;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            DATA: begin
                if (div_q == '0) begin
                    shift_d = {rxd_s, shift_q[BYTE_W-1:1]};
                    div_d   = FULL_LOAD;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(BYTE_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (div_q == '0) begin
                    par_d   = rxd_s;
                    div_d   = FULL_LOAD;
                    state_d = STOP;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (div_q == '0) begin
                    if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        if (par_q != ^shift_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        // A low stop bit also covers a line break; wait it out.
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
